// File: rtl/iic_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iic_cmd_arbiter
// Purpose  : Shares one IIC master engine between NUM_REQ codec command
//            requesters, with a bus-free gap and a watchdog abort.
//            Define IIC_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module iic_cmd_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int GAP_CYC     = 64,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                   MCLK,
  input  logic                   RESET,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [16*NUM_REQ-1:0]  REQ_DATA,
  output logic [NUM_REQ-1:0]     GNT,
  output logic [NUM_REQ-1:0]     DONE,
  output logic [NUM_REQ-1:0]     ERR,
  output logic                   BUSY,
  output logic                   TIMEOUT_FLAG,
  output logic                   IIC_ENABLE,
  output logic [15:0]            IIC_DATA,
  input  logic                   IIC_FINISHED
);

  localparam int          PW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [19:0] C_TIMEOUT_LAST = 20'(TIMEOUT_CYC - 1);
  localparam logic [9:0]  C_GAP_LAST     = 10'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t               r_state, w_state_nx;
  logic                 r_fin_meta, r_fin_sync, r_fin_prev;
  logic                 w_fin_rise;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nx;
  logic [NUM_REQ-1:0]   r_done, w_done_nx;
  logic [NUM_REQ-1:0]   r_err, w_err_nx;
  logic                 r_tflag, w_tflag_nx;
  logic                 r_en, w_en_nx;
  logic [15:0]          r_data, w_data_nx;
  logic [19:0]          r_timer, w_timer_nx;
  logic [9:0]           r_gap, w_gap_nx;
  logic                 w_any;
  logic [PW-1:0]        w_win;

  assign w_any = |REQ;

`ifdef IIC_ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (REQ[i]) w_win = PW'(i);
    end
  end
`else
  logic [PW-1:0] r_ptr;
  logic          w_found;

  // Search upward from the last winner so every pending requester gets a turn.
  always_comb begin : rr_search
    int idx;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && REQ[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_ptr <= PW'(NUM_REQ - 1);
    end else if (r_state == ST_IDLE && w_any) begin
      r_ptr <= w_win;
    end
  end
`endif

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_fin_meta <= 1'b0;
      r_fin_sync <= 1'b0;
      r_fin_prev <= 1'b0;
    end else begin
      r_fin_meta <= IIC_FINISHED;
      r_fin_sync <= r_fin_meta;
      r_fin_prev <= r_fin_sync;
    end
  end

  assign w_fin_rise = r_fin_sync & ~r_fin_prev;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_tflag <= 1'b0;
      r_en    <= 1'b0;
      r_data  <= '0;
      r_timer <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
      r_tflag <= w_tflag_nx;
      r_en    <= w_en_nx;
      r_data  <= w_data_nx;
      r_timer <= w_timer_nx;
      r_gap   <= w_gap_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_done_nx  = '0;
    w_err_nx   = '0;
    w_tflag_nx = r_tflag;
    w_en_nx    = r_en;
    w_data_nx  = r_data;
    w_timer_nx = r_timer;
    w_gap_nx   = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nx        = '0;
          w_gnt_nx[w_win] = 1'b1;
          w_data_nx       = REQ_DATA[16*int'(w_win) +: 16];
          w_timer_nx      = '0;
          w_state_nx      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_en_nx    = 1'b1;
        w_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // A finish coinciding with the watchdog expiry counts as success.
        if (w_fin_rise) begin
          w_done_nx  = r_gnt;
          w_gnt_nx   = '0;
          w_en_nx    = 1'b0;
          w_gap_nx   = '0;
          w_state_nx = ST_GAP;
        end else if (r_timer == C_TIMEOUT_LAST) begin
          w_err_nx   = r_gnt;
          w_tflag_nx = 1'b1;
          w_gnt_nx   = '0;
          w_en_nx    = 1'b0;
          w_gap_nx   = '0;
          w_state_nx = ST_GAP;
        end else begin
          w_timer_nx = r_timer + 20'd1;
        end
      end
      ST_GAP: begin
        if (r_gap == C_GAP_LAST) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_gap_nx = r_gap + 10'd1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign GNT          = r_gnt;
  assign DONE         = r_done;
  assign ERR          = r_err;
  assign BUSY         = (r_state != ST_IDLE);
  assign TIMEOUT_FLAG = r_tflag;
  assign IIC_ENABLE   = r_en;
  assign IIC_DATA     = r_data;

endmodule
`default_nettype wire

// File: tb/tb_iic_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iic_cmd_arbiter
// Purpose  : Scenario-driven bench for iic_cmd_arbiter with an expected-grant
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iic_cmd_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int GAP_CYC     = 8;
  localparam int TIMEOUT_CYC = 600;

  logic        mclk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] req_data = 32'h0;
  logic        iic_finished = 1'b0;
  logic [1:0]  gnt, done, err;
  logic        busy, timeout_flag, iic_enable;
  logic [15:0] iic_data;

  typedef struct {
    int          idx;
    logic [15:0] data;
    bit          to;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  iic_cmd_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .MCLK         (mclk),
    .RESET        (reset),
    .REQ          (req),
    .REQ_DATA     (req_data),
    .GNT          (gnt),
    .DONE         (done),
    .ERR          (err),
    .BUSY         (busy),
    .TIMEOUT_FLAG (timeout_flag),
    .IIC_ENABLE   (iic_enable),
    .IIC_DATA     (iic_data),
    .IIC_FINISHED (iic_finished)
  );

  always #10 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge mclk);
  endtask

  // what: 0 grant, 1 enable, 2 done/err, 3 not busy
  task automatic wait_for(input int what, input int max, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < max) begin
      if ((what == 0 && gnt != 2'b00) || (what == 1 && iic_enable) ||
          (what == 2 && (done != 2'b00 || err != 2'b00)) || (what == 3 && !busy)) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic push_exp(input int idx, input logic [15:0] data, input bit to);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.to   = to;
    sb.push_back(e);
  endtask

  task automatic pop_exp();
    if (sb.size() > 0) cur = sb.pop_front();
    else begin
      cur.idx = 0; cur.data = 16'h0; cur.to = 1'b0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({gnt, done, err, busy, timeout_flag, iic_enable, iic_data} !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b done=%b err=%b busy=%b tf=%b en=%b data=%h, need all 0",
               gnt, done, err, busy, timeout_flag, iic_enable, iic_data);
    end
    reset = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b gnt=%b, need 0/00", busy, gnt);
    end
  endtask

  task automatic test_single();
    bit ok;
    int bad = 0;
    req_data[15:0] = 16'h1E00;
    req = 2'b01;
    push_exp(0, 16'h1E00, 1'b0);
    tick();
    pop_exp();
    n_tests++;
    if (gnt !== 2'(1 << cur.idx) || iic_data !== cur.data) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b data=%h, need %b/%h", gnt, iic_data, 2'(1 << cur.idx), cur.data);
    end
    n_tests++;
    if (iic_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL single_en_early: en=%b one edge after req, need 0", iic_enable);
    end
    tick();
    n_tests++;
    if (iic_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL single_en_latency: en=%b two edges after req, need 1", iic_enable);
    end
    for (int i = 0; i < 500; i++) begin
      tick();
      if (iic_enable !== 1'b1 || done !== 2'b00 || err !== 2'b00 || iic_data !== 16'h1E00) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL single_hold: %0d bad cycles during transfer, need 0", bad);
    end
    iic_finished = 1'b1;
    wait_for(2, 10, ok);
    n_tests++;
    if (!ok || done !== 2'b01 || err !== 2'b00 || gnt !== 2'b00 || iic_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: done=%b err=%b gnt=%b en=%b, need 01/00/00/0", done, err, gnt, iic_enable);
    end
    req = 2'b00;
    iic_finished = 1'b0;
    tick();
    n_tests++;
    if (done !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done_pulse: done=%b one cycle later, need 00", done);
    end
    repeat (GAP_CYC - 2) tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_gap: busy=%b before gap end, need 1", busy);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_idle: busy=%b after gap, need 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t_fall = 0;
    apply_reset();
    req_data = {16'h0497, 16'h0017};
    req = 2'b11;
`ifdef IIC_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) push_exp(0, 16'h0017, 1'b0);
`else
    for (int i = 0; i < 4; i++) push_exp(i % 2, (i % 2 == 0) ? 16'h0017 : 16'h0497, 1'b0);
`endif
    for (int i = 0; i < 4; i++) begin
      wait_for(0, GAP_CYC + 10, ok);
      pop_exp();
      n_tests++;
      if (!ok || gnt !== 2'(1 << cur.idx) || iic_data !== cur.data) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: gnt=%b data=%h, need %b/%h", i, gnt, iic_data, 2'(1 << cur.idx), cur.data);
      end
      wait_for(1, 5, ok);
      if (i > 0) begin
        n_tests++;
        if (!ok || (cyc - t_fall) < GAP_CYC) begin
          n_fail++;
          $display("FAIL b2b_gap%0d: enable low %0d cycles, need >= %0d", i, cyc - t_fall, GAP_CYC);
        end
      end
      repeat (20) tick();
      iic_finished = 1'b1;
      wait_for(2, 10, ok);
      iic_finished = 1'b0;
      t_fall = cyc;
      n_tests++;
      if (!ok || done !== 2'(1 << cur.idx) || err !== 2'b00) begin
        n_fail++;
        $display("FAIL b2b_done%0d: done=%b err=%b, need %b/00", i, done, err, 2'(1 << cur.idx));
      end
    end
    req = 2'b00;
    wait_for(3, GAP_CYC + 5, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int t0;
    req_data[15:0] = 16'h1234;
    req = 2'b01;
    push_exp(0, 16'h1234, 1'b1);
    wait_for(0, GAP_CYC + 10, ok);
    t0 = cyc;
    pop_exp();
    n_tests++;
    if (!ok || gnt !== 2'(1 << cur.idx) || iic_data !== cur.data) begin
      n_fail++;
      $display("FAIL to_grant: gnt=%b data=%h, need %b/%h", gnt, iic_data, 2'(1 << cur.idx), cur.data);
    end
    wait_for(2, TIMEOUT_CYC + 20, ok);
    n_tests++;
    if (!ok || (cyc - t0) != TIMEOUT_CYC + 1) begin
      n_fail++;
      $display("FAIL to_latency: err after %0d cycles, need %0d", cyc - t0, TIMEOUT_CYC + 1);
    end
    n_tests++;
    if (err !== 2'(1 << cur.idx) || done !== 2'b00 || timeout_flag !== cur.to || gnt !== 2'b00 || iic_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err: err=%b done=%b tf=%b gnt=%b en=%b, need %b/00/1/00/0",
               err, done, timeout_flag, gnt, iic_enable, 2'(1 << cur.idx));
    end
    req = 2'b00;
    req_data[31:16] = 16'h0A5A;
    req = 2'b10;
    push_exp(1, 16'h0A5A, 1'b0);
    wait_for(0, GAP_CYC + 10, ok);
    pop_exp();
    n_tests++;
    if (!ok || gnt !== 2'(1 << cur.idx) || iic_data !== cur.data) begin
      n_fail++;
      $display("FAIL to_next_grant: gnt=%b data=%h, need %b/%h", gnt, iic_data, 2'(1 << cur.idx), cur.data);
    end
    repeat (10) tick();
    iic_finished = 1'b1;
    wait_for(2, 10, ok);
    iic_finished = 1'b0;
    req = 2'b00;
    n_tests++;
    if (!ok || done !== 2'b10 || timeout_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL to_next_done: done=%b tf=%b, need 10/1", done, timeout_flag);
    end
    wait_for(3, GAP_CYC + 5, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad = 0;
    req_data[15:0] = 16'h0C0F;
    req = 2'b01;
    wait_for(0, GAP_CYC + 10, ok);
    wait_for(1, 5, ok);
    repeat (5) tick();
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if ({gnt, done, err, busy, timeout_flag, iic_enable, iic_data} !== 25'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: gnt=%b done=%b err=%b busy=%b tf=%b en=%b data=%h, need all 0",
               gnt, done, err, busy, timeout_flag, iic_enable, iic_data);
    end
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 2'b00 || err !== 2'b00 || iic_enable !== 1'b0) bad++;
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: %0d cycles with activity in reset, need 0", bad);
    end
    push_exp(0, 16'h0C0F, 1'b0);
    pop_exp();
    n_tests++;
    if (gnt !== 2'(1 << cur.idx) || iic_data !== cur.data) begin
      n_fail++;
      $display("FAIL rstmid_first: gnt=%b data=%h, need %b/%h", gnt, iic_data, 2'(1 << cur.idx), cur.data);
    end
    repeat (10) tick();
    iic_finished = 1'b1;
    wait_for(2, 10, ok);
    iic_finished = 1'b0;
    req = 2'b00;
    n_tests++;
    if (!ok || done !== 2'b01 || err !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_done: done=%b err=%b, need 01/00", done, err);
    end
    wait_for(3, GAP_CYC + 5, ok);
  endtask

  task automatic test_spurious();
    bit ok;
    int bad = 0;
    iic_finished = 1'b1;
    repeat (3) tick();
    iic_finished = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 2'b00) begin
      n_fail++;
      $display("FAIL spur_idle: busy=%b done=%b, need 0/00", busy, done);
    end
    req_data[31:16] = 16'h1201;
    req = 2'b10;
    push_exp(1, 16'h1201, 1'b0);
    wait_for(0, 5, ok);
    pop_exp();
    n_tests++;
    if (!ok || gnt !== 2'(1 << cur.idx) || iic_data !== cur.data) begin
      n_fail++;
      $display("FAIL spur_grant: gnt=%b data=%h, need %b/%h", gnt, iic_data, 2'(1 << cur.idx), cur.data);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done !== 2'b00 || err !== 2'b00) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL spur_early_done: %0d cycles with done/err before finish, need 0", bad);
    end
    iic_finished = 1'b1;
    wait_for(2, 10, ok);
    iic_finished = 1'b0;
    req = 2'b00;
    n_tests++;
    if (!ok || done !== 2'b10) begin
      n_fail++;
      $display("FAIL spur_done: done=%b, need 10", done);
    end
    wait_for(3, GAP_CYC + 5, ok);
  endtask

  task automatic test_req_drop();
    bit ok;
    req_data[31:16] = 16'h0E55;
    req = 2'b10;
    push_exp(1, 16'h0E55, 1'b0);
    wait_for(0, 5, ok);
    pop_exp();
    n_tests++;
    if (!ok || gnt !== 2'(1 << cur.idx) || iic_data !== cur.data) begin
      n_fail++;
      $display("FAIL drop_grant: gnt=%b data=%h, need %b/%h", gnt, iic_data, 2'(1 << cur.idx), cur.data);
    end
    repeat (6) tick();
    req = 2'b00;
    repeat (10) tick();
    n_tests++;
    if (gnt !== 2'b10 || iic_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_hold: gnt=%b en=%b after req drop, need 10/1", gnt, iic_enable);
    end
    iic_finished = 1'b1;
    wait_for(2, 10, ok);
    iic_finished = 1'b0;
    n_tests++;
    if (!ok || done !== 2'b10 || err !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_done: done=%b err=%b, need 10/00", done, err);
    end
    wait_for(3, GAP_CYC + 5, ok);
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_req_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
